// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore control FSM sequencing the multi-cycle MIPS datapath,
// with a memory-ready handshake, a wait-cycle timeout and an illegal-opcode trap.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT   = 255,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       link,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    START, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC,
    R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, JAL, JR, TRAP
  } state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       ready, waiting, timeout;
  assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign waiting = state_q == FETCH || state_q == MEM_READ || state_q == MEM_WRITE;
  assign timeout = waiting && cnt_q == 8'(MEM_TIMEOUT) && !ready;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:     state_d = timeout ? TRAP : ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          6'h23, 6'h2B: state_d = MEM_ADDR;
          6'h00:        state_d = funct == 6'h08 ? JR : R_EXEC;
          6'h04:        state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h03:        state_d = JAL;
          6'h08:        state_d = ADDI_EXEC;
          default:      state_d = TRAP;
        endcase
      MEM_ADDR:  state_d = opcode == 6'h2B ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = timeout ? TRAP : ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = timeout ? TRAP : ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      default:   state_d = FETCH;
    endcase
  end
  // Counter restarts whenever the state changes, so each memory state gets its own budget.
  assign cnt_d   = state_d != state_q ? 8'd0 :
                   (waiting && !ready && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  assign cause_d = state_d == TRAP ? (state_q == DECODE ? 2'b01 : 2'b10) : cause_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    link          = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    trap          = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write  = !timeout;
        i_or_d     = 1'b1;
        instr_done = ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        reg_write  = 1'b1;
        link       = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      JR: begin
        pc_write   = 1'b1;
        pc_source  = 2'b11;
        instr_done = 1'b1;
      end
      TRAP:      trap = 1'b1;
      default: ;
    endcase
  end
  assign trap_cause = cause_q;
  assign state      = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed checks of the multi-cycle control FSM
// with a short memory timeout so the trap path is reachable quickly.
module tb_mips_multicycle_control;
  logic       clk = 1'b0, rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, link, reg_write, alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, alu_op, pc_source, trap_cause;
  logic [3:0] state;
  logic [24:0] outs;
  int total = 0, bad = 0, done_n, rw_n, mtr_n;
  mips_multicycle_control #(.MEM_TIMEOUT(4), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .link(link), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, link, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, instr_done, trap, trap_cause, state};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic run_seq(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] seq, input int n);
    opcode = op;
    funct  = fn;
    done_n = 0;
    rw_n   = 0;
    mtr_n  = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      chk(tag, 32'(state), 32'(seq[4*i+:4]));
      done_n += int'(instr_done);
      rw_n   += int'(reg_write);
      mtr_n  += int'(mem_to_reg);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick;
    tick;
    chk("reset_outs", 32'(outs), 32'h0);
    rst = 1'b1;
    tick;
    chk("fetch_state", 32'(state), 32'd1);
    chk("fetch_ctl", {28'd0, mem_read, ir_write, pc_write, i_or_d}, 32'hE);
    chk("fetch_alub", 32'(alu_src_b), 32'd1);
    run_seq("lw_seq", 6'h23, 6'h00, 32'h15432, 5);
    chk("lw_done", done_n, 1);
    chk("lw_rw", rw_n, 1);
    chk("lw_mtr", mtr_n, 1);
    // sw with three not-ready cycles in MEM_WRITE
    opcode = 6'h2B;
    tick;
    chk("sw_dec", 32'(state), 32'd2);
    tick;
    chk("sw_addr", 32'(state), 32'd3);
    chk("sw_addr_alu", {29'd0, alu_src_a, alu_src_b}, 32'h6);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      chk("sw_wr_state", 32'(state), 32'd6);
      chk("sw_wr_strobe", {30'd0, mem_write, i_or_d}, 32'h3);
      chk("sw_done", 32'(instr_done), 32'(i == 3));
    end
    tick;
    chk("sw_back", 32'(state), 32'd1);
    run_seq("r_seq", 6'h00, 6'h20, 32'h1872, 4);
    chk("r_done", done_n, 1);
    chk("r_rw", rw_n, 1);
    run_seq("beq_seq", 6'h04, 6'h00, 32'h192, 3);
    chk("beq_done", done_n, 1);
    run_seq("addi_seq", 6'h08, 6'h00, 32'h1CB2, 4);
    chk("addi_rw", rw_n, 1);
    run_seq("j_seq", 6'h02, 6'h00, 32'h1A2, 3);
    // jal then jr
    opcode = 6'h03;
    tick;
    tick;
    chk("jal_state", 32'(state), 32'd13);
    chk("jal_ctl", {28'd0, link, reg_write, pc_write, instr_done}, 32'hF);
    chk("jal_pcsrc", 32'(pc_source), 32'd2);
    opcode = 6'h00;
    funct  = 6'h08;
    tick;
    tick;
    tick;
    chk("jr_state", 32'(state), 32'd14);
    chk("jr_pcsrc", 32'(pc_source), 32'd3);
    chk("jr_ctl", {30'd0, reg_write, pc_write}, 32'h1);
    tick;
    chk("jr_back", 32'(state), 32'd1);
    // illegal opcode
    opcode = 6'h3F;
    tick;
    chk("ill_dec", 32'(state), 32'd2);
    tick;
    chk("ill_trap", {26'd0, state, trap, reg_write, mem_write}, 32'h7C);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    mem_ready = 1'b0;
    // FETCH timeout: counter 0..4 in FETCH, trap on the fifth cycle's edge
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("to_fetch", 32'(state), 32'd1);
      chk("to_nowr", {30'd0, ir_write, pc_write}, 32'h0);
    end
    chk("to_cause_hold", 32'(trap_cause), 32'd1);
    tick;
    chk("to_trap", {29'd0, state == 4'd15, trap_cause}, 32'h6);
    // ready arrives exactly when the counter hits the limit: no trap
    opcode = 6'h02;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 4) begin
        mem_ready = 1'b1;
        #1;
        chk("edge_irw", 32'(ir_write), 32'd1);
      end
      chk("edge_fetch", 32'(state), 32'd1);
    end
    tick;
    chk("edge_decode", {30'd0, state == 4'd2, trap}, 32'h2);
    tick;
    chk("edge_jump", 32'(state), 32'd10);
    // reset during a stalled MEM_READ
    opcode = 6'h23;
    tick;
    tick;
    tick;
    tick;
    chk("rst_mr", 32'(state), 32'd4);
    mem_ready = 1'b0;
    tick;
    chk("rst_mr_wait", 32'(state), 32'd4);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(outs), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    tick;
    chk("rst_release", 32'(state), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Moore control FSM that sequences the multi-cycle MIPS datapath: one shared memory, one ALU, and IR/MDR/A/B/ALUOut holding registers.
It decodes opcode/funct and steps each instruction through fetch, decode, execute, memory and writeback states.
It waits on a memory ready handshake and traps on illegal opcodes and memory timeouts.
It replaces the single-cycle main control when the team moves to the multi-cycle core.

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ready in any memory state before trapping (1..255).
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
opcode  input  6  IR[31:26], valid from DECODE onward.
funct  input  6  IR[5:0].
mem_ready  input  1  memory completes the current access this cycle.
pc_write  output  1  unconditional PC load.
pc_write_cond  output  1  PC load if ALU zero (datapath ANDs).
i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
ir_write  output  1  load IR.
mem_to_reg  output  1  writeback data from MDR.
reg_dst  output  1  destination register is rd.
link  output  1  destination $31, data = PC.
reg_write  output  1  register file write.
alu_src_a  output  1  0 = PC, 1 = A.
alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
alu_op  output  2  00 = add, 01 = sub, 10 = funct, 11 = reserved.
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr).
instr_done  output  1  one-cycle pulse in the final state of each retired instruction.
trap  output  1  one-cycle pulse in TRAP.
trap_cause  output  2  01 = illegal opcode, 10 = memory timeout; holds until the next trap or reset.
state  output  4  current state (debug/verification).

Behaviour:
- Reset:
  - rst=0 forces state=START (0).
  - All outputs 0, including trap_cause, and the wait counter is cleared.
  - Assertion mid-instruction aborts it immediately; no partial write strobe after the reset edge.
- Outputs are pure Moore decodes of the state register. Any control not listed for a state is 0.
- State encodings and actions:
  - START=0: all 0; next cycle goes to FETCH.
  - FETCH=1:
    - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - ir_write=pc_write=mem_ready; stay in FETCH until mem_ready, then go to DECODE.
  - DECODE=2: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0x23/0x2B -> MEM_ADDR
    - 0x00 with funct 0x08 -> JR; 0x00 otherwise -> R_EXEC
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - 0x08 -> ADDI_EXEC
    - anything else -> TRAP with cause 01
  - MEM_ADDR=3: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ=4: mem_read=1, i_or_d=1; wait for mem_ready, then go to MEM_WB.
  - MEM_WB=5: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - MEM_WRITE=6: mem_write=1, i_or_d=1; wait for mem_ready. instr_done=mem_ready.
  - R_EXEC=7: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB=8: reg_write=1, reg_dst=1, instr_done=1.
  - BRANCH=9: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - JUMP=10: pc_write=1, pc_source=10, instr_done=1.
  - ADDI_EXEC=11: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB=12: reg_write=1, reg_dst=0, instr_done=1.
  - JAL=13: reg_write=1, link=1, pc_write=1, pc_source=10, instr_done=1. PC already holds PC+4 from FETCH.
  - JR=14: pc_write=1, pc_source=11, instr_done=1.
  - TRAP=15: trap=1 for one cycle; trap_cause updated on entry; next state FETCH. The faulting instruction is skipped and PC is already +4.
- Every terminal state returns to FETCH.
- Cycle counts with zero memory wait:
  - lw 5, sw 4
  - R-type 4, addi 4
  - beq 3, j 3, jal 3, jr 3
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE; increments each cycle in those states while mem_ready=0.
  - When the counter equals MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with cause 10. No write strobe is issued in that last cycle.
  - mem_ready=1 on the cycle the counter reaches MEM_TIMEOUT wins: the access completes and there is no trap.
- The counter saturates and never wraps.
- Unused state encodings are unreachable and decode to START.

Test Plan:
1. Reset mid-lw: assert rst=0 during MEM_READ -> state=0 and all outputs 0 on the same edge. Release -> FETCH one cycle later.
2. lw (opcode 0x23), mem_ready tied 1 -> states 1,2,3,4,5; mem_to_reg=reg_write=1 only in state 5; instr_done pulses once; 5 cycles total.
3. sw (0x2B), mem_ready low 3 cycles in MEM_WRITE -> mem_write=1 for 4 cycles; instr_done on the 4th; total 7 cycles.
4. jal (0x03) then jr (0x00/0x08):
   - jal: state 13 with link=reg_write=pc_write=1, pc_source=10.
   - jr: state 14 with pc_source=11, reg_write=0.
5. Illegal opcode 0x3F -> DECODE then TRAP (trap=1, trap_cause=01), then FETCH; no reg_write or mem_write asserted.
6. MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 wait cycles, TRAP with cause 10. With mem_ready=1 on the 4th wait cycle instead -> normal DECODE, no trap.
